// File: rtl/ru.sv
// ru: reduction/update unit of the softmax-approximation datapath.
// Q4.12 signed fixed point. Three-stage pipeline:
//   stage 1: saturated signed difference (in_1-in_0 or in_0-in_1) plus the
//            selected multiplier constant (LOG2E or 1.0)
//   stage 2: diff * K >>> 12 (floor), saturated to 16 bits
//   stage 3: piecewise-linear 2^v, with out_0 carried along for alignment
// Ports:
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   en         pipeline enable; 0 freezes every register
//   valid_in   qualifies in_0/in_1/sel_mult/sel_mux
//   in_0       operand A (max or log2_sum)
//   in_1       operand B (x_i or y_i)
//   sel_mult   1: scale by LOG2E, 0: scale by 1.0
//   sel_mux    1: diff = in_1 - in_0, 0: diff = in_0 - in_1
//   out_0      scaled difference
//   out_1      2^out_0 approximation (non-negative)
//   valid_out  out_0/out_1 belong to a valid sample
module ru #(
  parameter int unsigned       DATA_W = 16,
  parameter int unsigned       FRAC_W = 12,
  parameter logic [DATA_W-1:0] LOG2E  = 16'h1715
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] in_0,
  input  logic [DATA_W-1:0] in_1,
  input  logic              sel_mult,
  input  logic              sel_mux,
  output logic [DATA_W-1:0] out_0,
  output logic [DATA_W-1:0] out_1,
  output logic              valid_out
);

  localparam int unsigned IW = DATA_W - FRAC_W;

  localparam logic [DATA_W-1:0] ONE  = {{(IW-1){1'b0}}, 1'b1, {FRAC_W{1'b0}}};
  localparam logic [DATA_W-1:0] MAXP = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MINN = {1'b1, {(DATA_W-1){1'b0}}};

  // Stage 1
  logic                     v1_q;
  logic signed [DATA_W-1:0] diff_q, diff_d;
  logic signed [DATA_W-1:0] k_q, k_d;
  logic        [DATA_W:0]   diff_w;

  // Stage 2
  logic                       v2_q;
  logic signed [DATA_W-1:0]   s2_q, s2_d;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [2*DATA_W-1:0] prod_sh;
  logic        [DATA_W:0]     prod_hi;

  // Stage 3
  logic              v3_q;
  logic [DATA_W-1:0] out0_q;
  logic [DATA_W-1:0] out1_q, pow_d;
  logic signed [IW-1:0] ip;
  logic        [IW-1:0] nsh;
  logic        [DATA_W-1:0] m_ext;
  int                   ip_i;

  // Stage 1: 17-bit difference, clamped back into 16 bits.
  always_comb begin
    diff_w = '0;
    if (sel_mux) begin
      diff_w = {in_1[DATA_W-1], in_1} - {in_0[DATA_W-1], in_0};
    end else begin
      diff_w = {in_0[DATA_W-1], in_0} - {in_1[DATA_W-1], in_1};
    end
    diff_d = diff_w[DATA_W-1:0];
    if (diff_w[DATA_W] != diff_w[DATA_W-1]) begin
      diff_d = diff_w[DATA_W] ? MINN : MAXP;
    end
    k_d = sel_mult ? LOG2E : ONE;
  end

  // Stage 2: arithmetic shift floors toward -inf; saturate if the bits
  // above the 16-bit result are not a pure sign extension.
  always_comb begin
    prod    = diff_q * k_q;
    prod_sh = prod >>> FRAC_W;
    prod_hi = prod_sh[2*DATA_W-1:DATA_W-1];
    s2_d    = prod_sh[DATA_W-1:0];
    if (prod_hi != '0 && prod_hi != '1) begin
      s2_d = prod_sh[2*DATA_W-1] ? MINN : MAXP;
    end
  end

  // Stage 3: 2^v with v = ip + f/4096, approximated as (1 + f/4096) * 2^ip.
  // Right shifts of 13+ drain the 13-bit mantissa to zero on their own.
  always_comb begin
    ip    = s2_q[DATA_W-1:FRAC_W];
    ip_i  = int'(ip);
    nsh   = ~ip + {{(IW-1){1'b0}}, 1'b1};
    m_ext = {{(IW-1){1'b0}}, 1'b1, s2_q[FRAC_W-1:0]};
    pow_d = '0;
    if (ip_i >= 3) begin
      pow_d = MAXP;
    end else if (ip_i >= 0) begin
      pow_d = m_ext << ip[1:0];
    end else begin
      pow_d = m_ext >> nsh;
    end
  end

  // Valid bits shift every enabled edge; data registers only load behind a
  // valid sample so the outputs hold through bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      diff_q <= '0;
      k_q    <= '0;
      s2_q   <= '0;
      out0_q <= '0;
      out1_q <= '0;
    end else if (en) begin
      v1_q <= valid_in;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (valid_in) begin
        diff_q <= diff_d;
        k_q    <= k_d;
      end
      if (v1_q) begin
        s2_q <= s2_d;
      end
      if (v2_q) begin
        out0_q <= s2_q;
        out1_q <= pow_d;
      end
    end
  end

  assign out_0     = out0_q;
  assign out_1     = out1_q;
  assign valid_out = v3_q;

endmodule

// File: tb/tb_ru.sv
module tb_ru;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        mux;
    logic        mult;
    logic [15:0] e0;
    logic [15:0] e1;
  } vec_t;

  localparam int unsigned NV = 13;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        valid_in;
  logic [15:0] in_0;
  logic [15:0] in_1;
  logic        sel_mult;
  logic        sel_mux;
  logic [15:0] out_0;
  logic [15:0] out_1;
  logic        valid_out;

  int n_cmp = 0;
  int n_err = 0;

  vec_t tbl [NV];

  ru #(.DATA_W(16), .FRAC_W(12), .LOG2E(16'h1715)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .valid_in  (valid_in),
    .in_0      (in_0),
    .in_1      (in_1),
    .sel_mult  (sel_mult),
    .sel_mux   (sel_mux),
    .out_0     (out_0),
    .out_1     (out_1),
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v, input logic vld);
    in_0     = v.a;
    in_1     = v.b;
    sel_mux  = v.mux;
    sel_mult = v.mult;
    valid_in = vld;
  endtask

  function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b,
                              input logic mux, input logic mult,
                              input logic [15:0] e0, input logic [15:0] e1);
    vec_t v;
    v.a = a; v.b = b; v.mux = mux; v.mult = mult; v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  // Per-cycle expectations for the stalled stream: valid_out and which
  // sample's values should be on the outputs (index into tbl).
  logic exp_v   [9];
  int   exp_idx [9];
  logic en_sch  [9];
  logic vld_sch [9];
  int   smp_sch [9];

  initial begin
    tbl[0]  = mk(16'h2400, 16'h1000, 1'b1, 1'b1, 16'hE325, 16'h04C9);
    tbl[1]  = mk(16'h1800, 16'hE316, 1'b0, 1'b0, 16'h34EA, 16'h7FFF);
    tbl[2]  = mk(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h1000);
    tbl[3]  = mk(16'h0000, 16'h1000, 1'b1, 1'b0, 16'h1000, 16'h2000);
    tbl[4]  = mk(16'h0000, 16'h8000, 1'b1, 1'b0, 16'h8000, 16'h0010);
    tbl[5]  = mk(16'h8000, 16'h7FFF, 1'b1, 1'b0, 16'h7FFF, 16'h7FFF);
    tbl[6]  = mk(16'h0000, 16'h7FFF, 1'b1, 1'b1, 16'h7FFF, 16'h7FFF);
    tbl[7]  = mk(16'h0000, 16'h8000, 1'b1, 1'b1, 16'h8000, 16'h0010);
    tbl[8]  = mk(16'h0800, 16'h0000, 1'b0, 1'b1, 16'h0B8A, 16'h1B8A);
    tbl[9]  = mk(16'h0000, 16'h0800, 1'b0, 1'b0, 16'hF800, 16'h0C00);
    tbl[10] = mk(16'h2FFF, 16'h0000, 1'b0, 1'b0, 16'h2FFF, 16'h7FFC);
    tbl[11] = mk(16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFE, 16'h0FFF);
    tbl[12] = mk(16'h2800, 16'h0000, 1'b0, 1'b0, 16'h2800, 16'h6000);

    en_sch  = '{1, 1, 1, 0, 0, 1, 1, 1, 1};
    vld_sch = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
    smp_sch = '{0, 3, 8, 5, 5, 9, 0, 0, 0};
    exp_v   = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
    exp_idx = '{12, 12, 0, 0, 0, 3, 8, 9, 9};

    // Reset with garbage inputs
    rst = 1'b1; en = 1'b1; valid_in = 1'b1;
    in_0 = 16'h1234; in_1 = 16'hABCD; sel_mult = 1'b1; sel_mux = 1'b0;
    step(); step();
    chk("rst_out0", 0, out_0, 16'h0000);
    chk("rst_out1", 0, out_1, 16'h0000);
    chk("rst_vout", 0, {15'd0, valid_out}, 16'h0000);
    @(negedge clk);
    rst = 1'b0; valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_vout", i, {15'd0, valid_out}, 16'h0000);
      chk("idle_out1", i, out_1, 16'h0000);
    end

    // Single-sample vectors; selects/operands scrambled after the sampling
    // edge to show they do not leak into the in-flight sample.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tbl[i], 1'b1);
      step();
      @(negedge clk);
      in_0 = 16'h5A5A; in_1 = 16'hC3C3;
      sel_mux = ~sel_mux; sel_mult = ~sel_mult; valid_in = 1'b0;
      step();
      chk("lat_vout2", i, {15'd0, valid_out}, 16'h0000);
      step();
      chk("vout", i, {15'd0, valid_out}, 16'h0001);
      chk("out0", i, out_0, tbl[i].e0);
      chk("out1", i, out_1, tbl[i].e1);
      step();
      chk("pulse_end", i, {15'd0, valid_out}, 16'h0000);
      chk("hold0", i, out_0, tbl[i].e0);
      chk("hold1", i, out_1, tbl[i].e1);
    end

    // Back-to-back stream of all vectors, throughput 1
    for (int c = 0; c < NV + 3; c++) begin
      @(negedge clk);
      if (c < NV) drive(tbl[c], 1'b1);
      else valid_in = 1'b0;
      step();
      if (c >= 2 && c - 2 < NV) begin
        chk("str_vout", c, {15'd0, valid_out}, 16'h0001);
        chk("str_out0", c, out_0, tbl[c-2].e0);
        chk("str_out1", c, out_1, tbl[c-2].e1);
      end else begin
        chk("str_vout", c, {15'd0, valid_out}, 16'h0000);
      end
    end

    // Four samples with en low for two cycles while sample 0 is presented
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      en = en_sch[j];
      drive(tbl[smp_sch[j]], vld_sch[j]);
      step();
      chk("stall_vout", j, {15'd0, valid_out}, {15'd0, exp_v[j]});
      chk("stall_out0", j, out_0, tbl[exp_idx[j]].e0);
      chk("stall_out1", j, out_1, tbl[exp_idx[j]].e1);
    end

    // Reset mid-flight: asynchronous clear, in-flight sample discarded
    @(negedge clk);
    drive(tbl[1], 1'b1);
    step();
    @(negedge clk);
    valid_in = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_out0", 0, out_0, 16'h0000);
    chk("arst_out1", 0, out_1, 16'h0000);
    chk("arst_vout", 0, {15'd0, valid_out}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_vout", i, {15'd0, valid_out}, 16'h0000);
      chk("post_out1", i, out_1, 16'h0000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
